// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the GPLL run-time reconfiguration sequencer.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PRE_RST,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_WAIT_LOCK
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_READY = 2'd1;
  localparam logic [1:0] ERR_LOCK  = 2'd2;
  localparam logic [1:0] ERR_CFG   = 2'd3;

  localparam logic [6:0] IDIV_MIN = 7'd1;
  localparam logic [6:0] IDIV_MAX = 7'd80;
  localparam logic [6:0] MDIV_MIN = 7'd1;
  localparam logic [6:0] ODIV_MIN = 7'd1;
  localparam logic [7:0] DUTY_MIN = 8'd2;

  localparam logic [4:0] DEF_ADDR_IDIV  = 5'd0;
  localparam logic [4:0] DEF_ADDR_MDIV  = 5'd1;
  localparam logic [4:0] DEF_ADDR_ODIV0 = 5'd2;
  localparam logic [4:0] DEF_ADDR_DUTY0 = 5'd3;

  // Upper limits of mdiv/odiv0/duty0 equal their field maxima, so only minima are tested.
  function automatic logic cfg_in_range(input logic [6:0] idiv, input logic [6:0] mdiv,
                                        input logic [6:0] odiv0, input logic [7:0] duty0);
    return (idiv >= IDIV_MIN) && (idiv <= IDIV_MAX) && (mdiv >= MDIV_MIN) &&
           (odiv0 >= ODIV_MIN) && (duty0 >= DUTY_MIN);
  endfunction

endpackage

// File: rtl/pll_apb_wr.sv
// Single-transfer APB write engine: setup phase while start is high, access phase
// until PREADY or until READY_TIMEOUT access cycles have elapsed.
module pll_apb_wr #(
  parameter int unsigned READY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  input  logic        apb_ready,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [4:0]  apb_addr,
  output logic [15:0] apb_wdata,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned CW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READY_TIMEOUT - 1);

  logic          active;
  logic [CW-1:0] cnt;

  assign done    = active && apb_ready;
  assign timeout = active && !apb_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (done || timeout) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Address and data buses are forced low outside a transfer.
  assign apb_sel   = start || active;
  assign apb_en    = active;
  assign apb_write = apb_sel;
  assign apb_addr  = apb_sel ? addr  : '0;
  assign apb_wdata = apb_sel ? wdata : '0;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Reprograms the GPLL dividers/duty over APB: range check, hold PLL reset, four
// register writes, release reset, wait for synchronised lock; watches lock while idle.
module pll_reconfig_ctrl import pll_reconfig_pkg::*; #(
  parameter logic [4:0]  ADDR_IDIV     = DEF_ADDR_IDIV,
  parameter logic [4:0]  ADDR_MDIV     = DEF_ADDR_MDIV,
  parameter logic [4:0]  ADDR_ODIV0    = DEF_ADDR_ODIV0,
  parameter logic [4:0]  ADDR_DUTY0    = DEF_ADDR_DUTY0,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned READY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT  = 4096
) (
  input  logic        apb_clk,
  input  logic        apb_rst_n,
  input  logic        cfg_req,
  input  logic [6:0]  cfg_idiv,
  input  logic [6:0]  cfg_mdiv,
  input  logic [6:0]  cfg_odiv0,
  input  logic [7:0]  cfg_duty0,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  cfg_err_code,
  output logic        lock_lost,
  input  logic        pll_lock,
  output logic        pll_rst,
  output logic [4:0]  apb_addr,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [15:0] apb_wdata,
  input  logic        apb_ready
);

  localparam int unsigned RW = (RST_CYCLES > 1)   ? $clog2(RST_CYCLES)   : 1;
  localparam int unsigned LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  state_t        state, next_state;
  logic [6:0]    idiv_q, mdiv_q, odiv0_q;
  logic [7:0]    duty0_q;
  logic [1:0]    idx;
  logic [RW-1:0] rst_cnt;
  logic [LW-1:0] lock_cnt;
  logic          lock_meta, lock_s, lock_s_d, locked_ok;
  logic          cfg_ok, rst_last, lock_last;
  logic          wr_start, wr_done, wr_timeout;
  logic [4:0]    wr_addr;
  logic [15:0]   wr_data;

  assign cfg_ok    = cfg_in_range(idiv_q, mdiv_q, odiv0_q, duty0_q);
  assign rst_last  = (rst_cnt == RST_LAST);
  assign lock_last = (lock_cnt == LOCK_LAST);
  assign wr_start  = (state == ST_WR_SETUP);
  assign cfg_busy  = (state != ST_IDLE);

  always_comb begin
    wr_addr = ADDR_IDIV;
    wr_data = {9'd0, idiv_q};
    case (idx)
      2'd0: begin wr_addr = ADDR_IDIV;  wr_data = {9'd0, idiv_q};  end
      2'd1: begin wr_addr = ADDR_MDIV;  wr_data = {9'd0, mdiv_q};  end
      2'd2: begin wr_addr = ADDR_ODIV0; wr_data = {9'd0, odiv0_q}; end
      2'd3: begin wr_addr = ADDR_DUTY0; wr_data = {8'd0, duty0_q}; end
      default: ;
    endcase
  end

  pll_apb_wr #(.READY_TIMEOUT(READY_TIMEOUT)) u_wr (
    .clk       (apb_clk),
    .rst_n     (apb_rst_n),
    .start     (wr_start),
    .addr      (wr_addr),
    .wdata     (wr_data),
    .apb_ready (apb_ready),
    .apb_sel   (apb_sel),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .done      (wr_done),
    .timeout   (wr_timeout)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:      if (cfg_req) next_state = ST_CHECK;
      ST_CHECK:     next_state = cfg_ok ? ST_PRE_RST : ST_IDLE;
      ST_PRE_RST:   if (rst_last) next_state = ST_WR_SETUP;
      ST_WR_SETUP:  next_state = ST_WR_ACCESS;
      ST_WR_ACCESS: begin
        if (wr_done)         next_state = (idx == 2'd3) ? ST_WAIT_LOCK : ST_WR_SETUP;
        else if (wr_timeout) next_state = ST_IDLE;
      end
      ST_WAIT_LOCK: if (lock_s || lock_last) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Status pulses are registered on the transition into IDLE, so busy drops with them.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state        <= ST_IDLE;
      idiv_q       <= '0;
      mdiv_q       <= '0;
      odiv0_q      <= '0;
      duty0_q      <= '0;
      idx          <= '0;
      rst_cnt      <= '0;
      lock_cnt     <= '0;
      lock_meta    <= 1'b0;
      lock_s       <= 1'b0;
      lock_s_d     <= 1'b0;
      locked_ok    <= 1'b0;
      pll_rst      <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_err_code <= ERR_NONE;
      lock_lost    <= 1'b0;
    end else begin
      state     <= next_state;
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      lock_s_d  <= lock_s;
      pll_rst   <= next_state inside {ST_PRE_RST, ST_WR_SETUP, ST_WR_ACCESS};
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      lock_lost <= 1'b0;
      rst_cnt   <= (state == ST_PRE_RST && !rst_last) ? rst_cnt + RW'(1) : '0;
      lock_cnt  <= (state == ST_WAIT_LOCK && !lock_last) ? lock_cnt + LW'(1) : '0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_req) begin
            idiv_q       <= cfg_idiv;
            mdiv_q       <= cfg_mdiv;
            odiv0_q      <= cfg_odiv0;
            duty0_q      <= cfg_duty0;
            cfg_err_code <= ERR_NONE;
            locked_ok    <= 1'b0;
          end else if (locked_ok && lock_s_d && !lock_s) begin
            lock_lost <= 1'b1;
            locked_ok <= 1'b0;
          end
        end
        ST_CHECK: begin
          idx <= '0;
          if (!cfg_ok) begin
            cfg_err      <= 1'b1;
            cfg_err_code <= ERR_CFG;
          end
        end
        ST_WR_ACCESS: begin
          if (wr_done) begin
            if (idx != 2'd3) idx <= idx + 2'd1;
          end else if (wr_timeout) begin
            cfg_err      <= 1'b1;
            cfg_err_code <= ERR_READY;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            cfg_done  <= 1'b1;
            locked_ok <= 1'b1;
          end else if (lock_last) begin
            cfg_err      <= 1'b1;
            cfg_err_code <= ERR_LOCK;
            locked_ok    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: responders for PREADY/LOCK, a cycle-level
// expectation model built from the sequencing rules, directed and randomized scenarios.
module tb_pll_reconfig_ctrl;

  localparam int RST_C   = 8;
  localparam int RDY_TO  = 64;
  localparam int LOCK_TO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [6:0]  cfg_idiv = '0, cfg_mdiv = '0, cfg_odiv0 = '0;
  logic [7:0]  cfg_duty0 = '0;
  logic        pll_lock = 1'b0, apb_ready = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err, lock_lost, pll_rst, apb_sel, apb_en, apb_write;
  logic [1:0]  cfg_err_code;
  logic [4:0]  apb_addr;
  logic [15:0] apb_wdata;

  int vectors = 0, miscompares = 0;
  int dly[4];
  int lock_dly, extra_req;
  int fld[4];
  int o_pre, o_nwr, o_fall, o_done_n, o_done_cnt, o_err_n, o_err_cnt, o_code;
  int o_unstable, o_viol, o_hung;
  int o_addr[4], o_data[4], o_en[4], o_setup[4];
  int e_nwr, e_fall, e_done_n, e_err_n, e_code;
  int e_en[4], e_setup[4];

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .RST_CYCLES    (RST_C),
    .READY_TIMEOUT (RDY_TO),
    .LOCK_TIMEOUT  (LOCK_TO)
  ) dut (
    .apb_clk      (clk),
    .apb_rst_n    (rst_n),
    .cfg_req      (cfg_req),
    .cfg_idiv     (cfg_idiv),
    .cfg_mdiv     (cfg_mdiv),
    .cfg_odiv0    (cfg_odiv0),
    .cfg_duty0    (cfg_duty0),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_err_code (cfg_err_code),
    .lock_lost    (lock_lost),
    .pll_lock     (pll_lock),
    .pll_rst      (pll_rst),
    .apb_addr     (apb_addr),
    .apb_sel      (apb_sel),
    .apb_en       (apb_en),
    .apb_write    (apb_write),
    .apb_wdata    (apb_wdata),
    .apb_ready    (apb_ready)
  );

  // Expected cycle numbers, counted from the clock edge that samples cfg_req (= 1).
  task automatic predict(input int idiv, input int mdiv, input int odiv, input int duty);
    bit ok;
    int s;
    fld = '{idiv, mdiv, odiv, duty};
    ok = idiv >= 1 && idiv <= 80 && mdiv >= 1 && odiv >= 1 && duty >= 2;
    e_nwr = 0; e_fall = -1; e_done_n = -1; e_err_n = -1; e_code = 0;
    e_en = '{0, 0, 0, 0}; e_setup = '{-1, -1, -1, -1};
    if (!ok) begin
      e_err_n = 2; e_code = 3;
      return;
    end
    s = 2 + RST_C;
    for (int i = 0; i < 4; i++) begin
      e_setup[i] = s; e_nwr = i + 1;
      if (dly[i] < 0) begin
        e_en[i] = RDY_TO; e_err_n = s + 1 + RDY_TO; e_code = 1; e_fall = e_err_n;
        return;
      end
      e_en[i] = dly[i] + 1;
      s = s + 2 + dly[i];
    end
    e_fall = s;
    if (lock_dly >= 0 && lock_dly + 2 < LOCK_TO) e_done_n = s + lock_dly + 3;
    else begin
      e_err_n = s + LOCK_TO; e_code = 2;
    end
  endtask

  task automatic run_seq(input int idiv, input int mdiv, input int odiv, input int duty);
    int n, cur;
    bit prev_rst;
    logic [4:0]  sa;
    logic [15:0] sd;
    o_pre = 0; o_nwr = 0; o_fall = -1; o_done_n = -1; o_done_cnt = 0; o_err_n = -1;
    o_err_cnt = 0; o_code = -1; o_unstable = 0; o_viol = 0; o_hung = 0;
    o_addr = '{-1, -1, -1, -1}; o_data = '{-1, -1, -1, -1};
    o_en = '{0, 0, 0, 0}; o_setup = '{-1, -1, -1, -1};
    sa = '0; sd = '0; prev_rst = 1'b0; n = 0;
    @(negedge clk);
    cfg_idiv = idiv[6:0]; cfg_mdiv = mdiv[6:0]; cfg_odiv0 = odiv[6:0]; cfg_duty0 = duty[7:0];
    cfg_req = 1'b1;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1 || n == extra_req + 1) cfg_req = 1'b0;
      if (n == extra_req) cfg_req = 1'b1;
      if (!apb_sel && apb_write) o_viol++;
      if (apb_sel && !apb_en) begin
        if (o_nwr < 4) begin
          o_addr[o_nwr] = int'(apb_addr); o_data[o_nwr] = int'(apb_wdata); o_setup[o_nwr] = n;
        end
        o_nwr++; sa = apb_addr; sd = apb_wdata;
        if (!apb_write) o_viol++;
      end else if (apb_en && (!apb_sel || !apb_write || apb_addr !== sa || apb_wdata !== sd))
        o_unstable++;
      if (apb_en && o_nwr >= 1 && o_nwr <= 4) o_en[o_nwr-1]++;
      if (pll_rst && o_nwr == 0) o_pre++;
      if (prev_rst && !pll_rst && o_fall < 0) o_fall = n;
      if (cfg_done) begin o_done_cnt++; o_done_n = n; end
      if (cfg_err) begin o_err_cnt++; o_err_n = n; o_code = int'(cfg_err_code); end
      cur = o_nwr - 1;
      if (apb_en && cur >= 0 && cur < 4) apb_ready = (dly[cur] >= 0 && o_en[cur] == dly[cur] + 1);
      else apb_ready = 1'($urandom_range(0, 1));
      if (pll_rst) pll_lock = 1'b0;
      else if (o_fall >= 0 && lock_dly >= 0 && n == o_fall + lock_dly) pll_lock = 1'b1;
      prev_rst = pll_rst;
      if (!cfg_busy) break;
      if (n > 3000) begin o_hung = 1; break; end
    end
    cfg_req = 1'b0; apb_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({cfg_busy, cfg_done, cfg_err, cfg_err_code, lock_lost, pll_rst, apb_sel, apb_en,
         apb_write, apb_addr, apb_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs busy=%b done=%b err=%b code=%0d rst=%b sel=%b en=%b addr=%0d wdata=%0d, all required 0",
               cfg_busy, cfg_done, cfg_err, cfg_err_code, pll_rst, apb_sel, apb_en, apb_addr, apb_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_happy();
    dly = '{0, 0, 0, 0}; lock_dly = 100; extra_req = 0;
    predict(1, 2, 12, 12);
    run_seq(1, 2, 12, 12);
    vectors++;
    if (o_pre !== RST_C) begin
      miscompares++; $display("FAIL happy_pre_rst cycles=%0d required=%0d", o_pre, RST_C);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o_addr[i] !== i || o_data[i] !== fld[i] || o_setup[i] !== e_setup[i] || o_en[i] !== 1) begin
        miscompares++;
        $display("FAIL happy_write%0d addr=%0d data=%0d setup=%0d en=%0d required %0d/%0d/%0d/1",
                 i, o_addr[i], o_data[i], o_setup[i], o_en[i], i, fld[i], e_setup[i]);
      end
    end
    vectors++;
    if (o_nwr !== 4 || o_fall !== e_fall) begin
      miscompares++; $display("FAIL happy_writes nwr=%0d fall=%0d required 4/%0d", o_nwr, o_fall, e_fall);
    end
    vectors++;
    if (o_done_n !== e_done_n || o_done_cnt !== 1 || o_err_cnt !== 0 || cfg_err_code !== 2'd0) begin
      miscompares++;
      $display("FAIL happy_done at=%0d cnt=%0d errs=%0d code=%0d required at=%0d cnt=1 errs=0 code=0",
               o_done_n, o_done_cnt, o_err_cnt, cfg_err_code, e_done_n);
    end
    vectors++;
    if (o_unstable + o_viol + o_hung !== 0) begin
      miscompares++;
      $display("FAIL happy_protocol unstable=%0d viol=%0d hung=%0d required 0", o_unstable, o_viol, o_hung);
    end
    @(negedge clk);
    vectors++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
      miscompares++; $display("FAIL happy_after done=%b busy=%b required 0/0", cfg_done, cfg_busy);
    end
  endtask

  task automatic test_wait_states();
    dly = '{3, 3, 3, 3}; lock_dly = 20; extra_req = 0;
    predict(80, 127, 127, 255);
    run_seq(80, 127, 127, 255);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o_en[i] !== 4 || o_addr[i] !== i || o_data[i] !== fld[i]) begin
        miscompares++;
        $display("FAIL wait_write%0d en=%0d addr=%0d data=%0d required 4/%0d/%0d", i, o_en[i], o_addr[i], o_data[i], i, fld[i]);
      end
    end
    vectors++;
    if (o_unstable !== 0 || o_done_n !== e_done_n || o_done_cnt !== 1) begin
      miscompares++;
      $display("FAIL wait_done unstable=%0d at=%0d cnt=%0d required 0/%0d/1", o_unstable, o_done_n, o_done_cnt, e_done_n);
    end
  endtask

  task automatic test_ready_timeout();
    dly = '{0, -1, 0, 0}; lock_dly = 10; extra_req = 0;
    predict(5, 6, 7, 8);
    run_seq(5, 6, 7, 8);
    vectors++;
    if (o_nwr !== 2 || o_en[1] !== RDY_TO) begin
      miscompares++; $display("FAIL rdy_to_writes nwr=%0d en=%0d required 2/%0d", o_nwr, o_en[1], RDY_TO);
    end
    vectors++;
    if (o_err_n !== e_err_n || o_code !== 1 || o_fall !== e_err_n || o_done_cnt !== 0) begin
      miscompares++;
      $display("FAIL rdy_to_err at=%0d code=%0d fall=%0d done=%0d required %0d/1/%0d/0",
               o_err_n, o_code, o_fall, o_done_cnt, e_err_n, e_err_n);
    end
  endtask

  task automatic test_lock_timeout();
    dly = '{1, 0, 2, 0}; lock_dly = -1; extra_req = 0;
    predict(3, 40, 9, 100);
    run_seq(3, 40, 9, 100);
    vectors++;
    if (o_err_n - o_fall !== LOCK_TO || o_err_n !== e_err_n || o_code !== 2 || o_err_cnt !== 1) begin
      miscompares++;
      $display("FAIL lock_to at=%0d fall=%0d code=%0d cnt=%0d required at=%0d fall+%0d code=2 cnt=1",
               o_err_n, o_fall, o_code, o_err_cnt, e_err_n, LOCK_TO);
    end
  endtask

  task automatic test_bad_cfg();
    dly = '{0, 0, 0, 0}; lock_dly = 5; extra_req = 0;
    predict(0, 10, 10, 10);
    run_seq(0, 10, 10, 10);
    vectors++;
    if (o_err_n !== 2 || o_code !== 3 || o_nwr !== 0 || o_pre !== 0 || o_fall !== -1) begin
      miscompares++;
      $display("FAIL bad_cfg at=%0d code=%0d nwr=%0d pre=%0d fall=%0d required 2/3/0/0/-1",
               o_err_n, o_code, o_nwr, o_pre, o_fall);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (cfg_err_code !== 2'd3 || cfg_err !== 1'b0) begin
      miscompares++; $display("FAIL bad_cfg_hold code=%0d err=%b required 3/0", cfg_err_code, cfg_err);
    end
  endtask

  task automatic test_lock_loss_and_ignored_req();
    int quiet, first, pulses;
    dly = '{0, 1, 0, 0}; lock_dly = 30; extra_req = 5;
    predict(7, 7, 7, 7);
    run_seq(7, 7, 7, 7);
    extra_req = 0;
    vectors++;
    if (o_done_cnt !== 1 || o_done_n !== e_done_n || o_nwr !== 4) begin
      miscompares++;
      $display("FAIL ignored_req_seq done=%0d at=%0d nwr=%0d required 1/%0d/4", o_done_cnt, o_done_n, o_nwr, e_done_n);
    end
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (cfg_busy || apb_sel || pll_rst) quiet++;
    end
    vectors++;
    if (quiet !== 0) begin
      miscompares++; $display("FAIL ignored_req_idle active_cycles=%0d required 0", quiet);
    end
    pll_lock = 1'b0; first = -1; pulses = 0;
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      if (lock_lost) begin pulses++; if (first < 0) first = m; end
    end
    vectors++;
    if (first !== 3 || pulses !== 1) begin
      miscompares++; $display("FAIL lock_lost at=%0d pulses=%0d required 3/1", first, pulses);
    end
    pll_lock = 1'b1; repeat (6) @(negedge clk);
    pll_lock = 1'b0; pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (lock_lost) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++; $display("FAIL lock_lost_rearm pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_reset_mid_write();
    int waited, active;
    @(negedge clk);
    cfg_idiv = 7'd4; cfg_mdiv = 7'd4; cfg_odiv0 = 7'd4; cfg_duty0 = 8'd4; cfg_req = 1'b1;
    apb_ready = 1'b0;
    @(negedge clk); cfg_req = 1'b0;
    waited = 0;
    while (!apb_en && waited < 50) begin @(negedge clk); waited++; end
    vectors++;
    if (!apb_en) begin
      miscompares++; $display("FAIL reset_mid_reach en=%b required 1 within 50 cycles", apb_en);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({apb_sel, apb_en, pll_rst, cfg_busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort sel=%b en=%b rst=%b busy=%b required 0", apb_sel, apb_en, pll_rst, cfg_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; active = 0;
    repeat (6) begin
      @(negedge clk);
      if (cfg_busy || apb_sel || pll_rst || cfg_done || cfg_err) active++;
    end
    vectors++;
    if (active !== 0) begin
      miscompares++; $display("FAIL reset_mid_idle active_cycles=%0d required 0", active);
    end
  endtask

  task automatic test_random();
    int fi, fm, fo, fd;
    for (int t = 0; t < 10; t++) begin
      fi = $urandom_range(0, 100); fm = $urandom_range(0, 127);
      fo = $urandom_range(0, 127); fd = $urandom_range(0, 255);
      for (int i = 0; i < 4; i++) dly[i] = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
      lock_dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 150));
      extra_req = int'($urandom_range(0, 30));
      predict(fi, fm, fo, fd);
      run_seq(fi, fm, fo, fd);
      vectors++;
      if (o_nwr !== e_nwr || o_fall !== e_fall || o_hung !== 0) begin
        miscompares++;
        $display("FAIL rand%0d_flow nwr=%0d fall=%0d hung=%0d required %0d/%0d/0", t, o_nwr, o_fall, o_hung, e_nwr, e_fall);
      end
      for (int i = 0; i < e_nwr; i++) begin
        vectors++;
        if (o_addr[i] !== i || o_data[i] !== fld[i] || o_setup[i] !== e_setup[i] || o_en[i] !== e_en[i]) begin
          miscompares++;
          $display("FAIL rand%0d_write%0d addr=%0d data=%0d setup=%0d en=%0d required %0d/%0d/%0d/%0d",
                   t, i, o_addr[i], o_data[i], o_setup[i], o_en[i], i, fld[i], e_setup[i], e_en[i]);
        end
      end
      vectors++;
      if (o_done_n !== e_done_n || o_err_n !== e_err_n || o_done_cnt !== int'(e_done_n >= 0) ||
          o_err_cnt !== int'(e_err_n >= 0) || (e_err_n >= 0 && o_code !== e_code)) begin
        miscompares++;
        $display("FAIL rand%0d_result done=%0d err=%0d code=%0d required done=%0d err=%0d code=%0d",
                 t, o_done_n, o_err_n, o_code, e_done_n, e_err_n, e_code);
      end
      vectors++;
      if (o_unstable + o_viol !== 0) begin
        miscompares++; $display("FAIL rand%0d_protocol unstable=%0d viol=%0d required 0", t, o_unstable, o_viol);
      end
    end
  endtask

  initial begin
    extra_req = 0; lock_dly = 0; dly = '{0, 0, 0, 0};
    test_reset();
    test_happy();
    test_wait_states();
    test_ready_timeout();
    test_lock_timeout();
    test_bad_cfg();
    test_lock_loss_and_ignored_req();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- APB master sequencer that reprograms the GPLL's input divider, feedback divider, CLKOUT0 divider and CLKOUT0 duty at run time over the PLL's 5-bit/16-bit APB reconfiguration port.
- Holds the PLL in reset during the writes, releases it, waits for LOCK with a timeout, and reports done or error.
- Also monitors lock loss while idle.
- Sits beside the PLL wrapper and runs on the APB clock.

Parameters:
- ADDR_IDIV, 5'd0, APB address of the input divider register
- ADDR_MDIV, 5'd1, APB address of the feedback divider register
- ADDR_ODIV0, 5'd2, APB address of the CLKOUT0 divider register
- ADDR_DUTY0, 5'd3, APB address of the CLKOUT0 duty register
- RST_CYCLES, 8, cycles pll_rst is held before the first write (>=1)
- READY_TIMEOUT, 64, max access-phase cycles waiting for apb_ready
- LOCK_TIMEOUT, 4096, max cycles waiting for synced lock after reset release

Ports:
- apb_clk  in  1  controller clock, also drives the PLL APB_CLK
- apb_rst_n  in  1  asynchronous active-low reset
- cfg_req  in  1  start pulse; sampled only in IDLE
- cfg_idiv  in  7  input divider, valid 1..80
- cfg_mdiv  in  7  feedback divider, valid 1..127
- cfg_odiv0  in  7  CLKOUT0 divider, valid 1..127
- cfg_duty0  in  8  CLKOUT0 duty, valid 2..255
- cfg_busy  out  1  sequence in progress
- cfg_done  out  1  one-cycle success pulse
- cfg_err  out  1  one-cycle failure pulse
- cfg_err_code  out  2  1=ready timeout, 2=lock timeout, 3=bad config; held until next cfg_req
- lock_lost  out  1  one-cycle pulse, synced lock falls while IDLE after a success
- pll_lock  in  1  PLL LOCK, asynchronous to apb_clk
- pll_rst  out  1  PLL RST
- apb_addr  out  5  register address
- apb_sel  out  1  PSEL
- apb_en  out  1  PENABLE
- apb_write  out  1  PWRITE
- apb_wdata  out  16  write data, field zero-extended
- apb_ready  in  1  PREADY

Behaviour:
- Reset values:
  - All outputs 0; cfg_err_code=0; FSM in IDLE.
  - The internal "locked_ok" flag is 0.
  - Both lock synchroniser flops are 0.
- pll_lock is synchronised with a 2-flop synchroniser to produce lock_s. All lock decisions use lock_s.
- FSM states: IDLE, CHECK, PRE_RST, WR_SETUP, WR_ACCESS, WAIT_LOCK.
- IDLE:
  - cfg_req=1 registers all four cfg fields, clears cfg_err_code, sets cfg_busy, and moves to CHECK.
  - cfg_req is ignored in every other state.
- CHECK (1 cycle):
  - If any field is out of range: cfg_err pulse, cfg_err_code=3, go to IDLE. No APB traffic, pll_rst untouched.
  - Otherwise go to PRE_RST.
- PRE_RST:
  - pll_rst=1 for exactly RST_CYCLES cycles, then go to WR_SETUP with write index=0.
  - Write order: IDIV, MDIV, ODIV0, DUTY0.
- WR_SETUP (1 cycle):
  - Drive apb_sel=1, apb_en=0, apb_write=1.
  - Drive addr/wdata for the current index.
- WR_ACCESS:
  - apb_en=1; addr/wdata/sel/write stay stable.
  - Stays while apb_ready=0.
  - On apb_ready=1: that cycle completes the write; next cycle sel/en=0.
    - If index<3: index+1, go to WR_SETUP.
    - Else: pll_rst=0, go to WAIT_LOCK.
  - Back-to-back writes therefore take 2 cycles each when ready is already high.
  - If the timeout counter reaches READY_TIMEOUT with no ready: sel/en=0, pll_rst=0, cfg_err pulse, code 1, go to IDLE.
- WAIT_LOCK:
  - Counter starts at 0 on entry.
  - lock_s=1: cfg_done pulse, locked_ok=1, go to IDLE.
  - Counter reaches LOCK_TIMEOUT: cfg_err pulse, code 2, locked_ok=0, go to IDLE.
- cfg_busy=1 in every state except IDLE. It falls in the same cycle as the done/err pulse.
- locked_ok is cleared when a sequence starts.
- lock_lost fires on a falling edge of lock_s in IDLE with locked_ok=1; locked_ok then clears.
- Counters are sized with $clog2 of their parameter and must not wrap.
- A reset mid-sequence aborts immediately: apb_sel/apb_en/pll_rst all go to 0 asynchronously.
- apb_write is 0 whenever apb_sel is 0.

Decomposition:
- pll_reconfig_pkg:
  - FSM state enum
  - error code constants (ERR_NONE=0, ERR_READY=1, ERR_LOCK=2, ERR_CFG=3)
  - field range limits
  - default register addresses
- One sub-module, pll_apb_wr: single-transfer APB write engine with a READY_TIMEOUT counter. Interface: start, addr, wdata → done/timeout. The FSM instantiates it once.

Test Plan:
- Happy path:
  - Stimulus: cfg 1/2/12/12, apb_ready tied 1, pll_lock rising 100 cycles after pll_rst falls.
  - Response: pll_rst high 8 cycles; 4 writes at addr 0,1,2,3 with wdata 1,2,12,12, each 2 cycles; cfg_done once; busy low.
- Wait states:
  - Stimulus: apb_ready delayed 3 cycles per write.
  - Response: apb_en high 4 cycles per write; addr/wdata stable throughout; done.
- Ready timeout:
  - Stimulus: READY_TIMEOUT=64, apb_ready=0 on the second write.
  - Response: cfg_err with code 1 after 64 access cycles; pll_rst=0; no third write.
- Lock timeout and bad config:
  - Stimulus A: pll_lock held 0, LOCK_TIMEOUT=200.
  - Response A: err code 2 exactly 200 cycles after pll_rst falls.
  - Stimulus B: cfg_idiv=0.
  - Response B: err code 3 two cycles after req; zero APB cycles.
- Lock loss and ignored request:
  - Stimulus: after done, drop pll_lock; separately assert cfg_req during busy.
  - Response: lock_lost pulses once, 3 cycles after the drop; the mid-busy req produces no second sequence.
- Reset mid-write:
  - Stimulus: apb_rst_n low during WR_ACCESS.
  - Response: sel/en/pll_rst are 0 immediately; after release, FSM is in IDLE and busy=0.
